// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down counter timer and its up-counter sibling.
package down_counter_timer_pkg;

    // Default counter width, shared with the 4-bit up counter.
    localparam int DEFAULT_WIDTH = 4;

    // Timer control states; the unused code 2'd3 recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down counter timer.
//
// Handshake note: there is no valid/ready pairing here. load and start are
// single-cycle strobes sampled on every rising clk edge (load wins over start),
// en is a level qualifier, and all status outputs are registered or decoded
// from registered state, so they are stable for the whole cycle after an edge.
interface down_counter_timer_if
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             reload_mode;
    logic [WIDTH-1:0] q;
    logic             borrow;
    logic             done;
    logic             busy;
    state_t           state;

    modport master (
        output en, load, load_val, start, reload_mode,
        input  q, borrow, done, busy, state
    );

    modport slave (
        input  en, load, load_val, start, reload_mode,
        output q, borrow, done, busy, state
    );
endinterface

// File: rtl/down_counter_core.sv
// Datapath of the timer: preset and count registers plus a zero flag.
// Control strobes are mutually prioritised: load > reload > dec.
module down_counter_core
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             reload,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    logic [WIDTH-1:0] preset;

    // Preset and count registers; dec is only issued by the FSM when q != 0,
    // so the subtraction never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            preset <= '0;
            q      <= '0;
        end else if (load) begin
            preset <= load_val;
            q      <= load_val;
        end else if (reload) begin
            q <= preset;
        end else if (dec) begin
            q <= q - WIDTH'(1);
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot and auto-reload modes.
// Emits a one-cycle borrow pulse at each terminal event (q==0 on an
// enabled RUN edge).
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    down_counter_timer_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic             borrow;
    logic             borrow_nxt;
    logic             core_reload;
    logic             core_dec;
    logic [WIDTH-1:0] q;
    logic             zero;

    down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.load),
        .load_val (bus.load_val),
        .reload   (core_reload),
        .dec      (core_dec),
        .q        (q),
        .zero     (zero)
    );

    // State and borrow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            borrow <= 1'b0;
        end else begin
            state  <= state_nxt;
            borrow <= borrow_nxt;
        end
    end

    // Next state and datapath controls: load > start > counting.
    always_comb begin
        state_nxt   = state;
        borrow_nxt  = 1'b0;
        core_reload = 1'b0;
        core_dec    = 1'b0;
        if (bus.load) begin
            state_nxt = ST_IDLE;
        end else if (bus.start) begin
            core_reload = 1'b1;
            state_nxt   = ST_RUN;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_DONE: state_nxt = ST_DONE;
                ST_RUN: begin
                    if (bus.en) begin
                        if (zero) begin
                            borrow_nxt = 1'b1;
                            if (bus.reload_mode) begin
                                core_reload = 1'b1;
                            end else begin
                                state_nxt = ST_DONE;
                            end
                        end else begin
                            core_dec = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.q      = q;
    assign bus.borrow = borrow;
    assign bus.busy   = (state == ST_RUN);
    assign bus.done   = (state == ST_DONE);
    assign bus.state  = state;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed literal checks plus a
// randomized run compared every cycle against a period-based reference model.
module tb_down_counter_timer;
    import down_counter_timer_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    down_counter_timer_if #(.WIDTH(W)) bus ();

    down_counter_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts enabled edges since the last start (m_k).
    // In RUN, q is preset - m_k; the terminal event is edge preset+1.
    int m_preset;
    int m_hold;   // q value shown in IDLE/DONE
    int m_k;
    int m_mode;   // 0 idle, 1 run, 2 done
    int m_borrow;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_preset = 0;
            m_hold   = 0;
            m_k      = 0;
            m_mode   = 0;
            m_borrow = 0;
        end else begin
            m_borrow = 0;
            if (bus.load) begin
                m_preset = int'(bus.load_val);
                m_hold   = m_preset;
                m_mode   = 0;
            end else if (bus.start) begin
                m_k    = 0;
                m_mode = 1;
            end else if (m_mode == 1 && bus.en) begin
                m_k++;
                if (m_k == m_preset + 1) begin
                    m_borrow = 1;
                    if (bus.reload_mode) begin
                        m_k = 0;
                    end else begin
                        m_mode = 2;
                        m_hold = 0;
                    end
                end
            end
        end
    end

    function automatic int model_q();
        return (m_mode == 1) ? (m_preset - m_k) : m_hold;
    endfunction

    // Compare process: every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_q",      32'(bus.q),      32'(model_q()));
            chk("cyc_borrow", 32'(bus.borrow), 32'(m_borrow));
            chk("cyc_busy",   32'(bus.busy),   32'(m_mode == 1));
            chk("cyc_done",   32'(bus.done),   32'(m_mode == 2));
            chk("cyc_state",  32'(bus.state),  32'(m_mode));
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge.
    task automatic drive(input logic ld, input logic [W-1:0] lv, input logic st,
                         input logic e, input logic rm);
        bus.load        = ld;
        bus.load_val    = lv;
        bus.start       = st;
        bus.en          = e;
        bus.reload_mode = rm;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int exp_seq[9];
        int rnd_rst;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("reset_q",    32'(bus.q),    0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        rst = 1'b1;
        tick();

        // One-shot from 3.
        drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
        chk("os_start_q", 32'(bus.q), 3);
        chk("os_start_busy", 32'(bus.busy), 1);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick(); chk("os_q2", 32'(bus.q), 2);
        tick(); chk("os_q1", 32'(bus.q), 1);
        tick(); chk("os_q0", 32'(bus.q), 0); chk("os_no_borrow", 32'(bus.borrow), 0);
        tick();
        chk("os_borrow", 32'(bus.borrow), 1);
        chk("os_done", 32'(bus.done), 1);
        chk("os_busy", 32'(bus.busy), 0);
        tick();
        chk("os_borrow_end", 32'(bus.borrow), 0);
        chk("os_q_hold", 32'(bus.q), 0);

        // Auto-reload with preset 2.
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1); tick();
        chk("ar_start_q", 32'(bus.q), 2);
        exp_seq = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("ar_q", 32'(bus.q), 32'(exp_seq[i]));
            chk("ar_borrow", 32'(bus.borrow), 32'((i % 3) == 2));
            chk("ar_done", 32'(bus.done), 0);
        end

        // Enable gating with preset 5.
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        chk("gate_q4", 32'(bus.q), 4);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gate_hold", 32'(bus.q), 4);
            chk("gate_borrow", 32'(bus.borrow), 0);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        chk("gate_resume", 32'(bus.q), 3);

        // Load beats start.
        drive(1'b1, 4'd7, 1'b1, 1'b1, 1'b0); tick();
        chk("prio_q", 32'(bus.q), 7);
        chk("prio_busy", 32'(bus.busy), 0);
        chk("prio_state", 32'(bus.state), 32'(ST_IDLE));

        // Restart mid-run from preset 9.
        drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); repeat (3) tick();
        chk("rs_q6", 32'(bus.q), 6);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0); tick();
        chk("rs_q9", 32'(bus.q), 9);
        chk("rs_busy", 32'(bus.busy), 1);

        // Preset 0: first enabled edge is terminal.
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
        chk("p0_q", 32'(bus.q), 0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        chk("p0_borrow", 32'(bus.borrow), 1);
        chk("p0_done", 32'(bus.done), 1);

        // Async reset mid-run, away from any clock edge.
        drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        #1 rst = 1'b0;
        #1;
        chk("arst_q", 32'(bus.q), 0);
        chk("arst_borrow", 32'(bus.borrow), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        rst = 1'b1;
        tick();

        // Randomized run against the model.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 99) < 5),
                  W'($urandom_range(0, (1 << W) - 1) % 6),
                  1'($urandom_range(0, 99) < 7),
                  1'($urandom_range(0, 99) < 80),
                  1'($urandom_range(0, 1)));
            rnd_rst = int'($urandom_range(0, 299));
            if (rnd_rst == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
